mult_bus_master: RTL
====================

# mult_bus_master

Bus initiator that drives the multiplier peripheral's register map on behalf of a local client. It accepts two 16-bit operands through a ready/valid handshake and performs the full bus sequence: write A, write B, pulse init, poll done, read pp. It then returns the 32-bit product, or a timeout error, through a second ready/valid handshake. It sits between a sequencing block, such as the calculator control unit, and the peripheral's `cs/addr/rd/wr/d_in/d_out` port.

## Interface
- `DATA_W`, 16: operand width and bus write-data width.
- `ADDR_W`, 5: bus address width.
- `TIMEOUT`, 1023: maximum number of done-polls that read 0 before the block aborts with `error`.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low. Asserting it forces the idle state and the reset values immediately.
- `start` in 1: operand-valid request from the client.
- `start_ready` out 1: high exactly when the block is in IDLE. Combinational from the state; reads 1 during reset.
- `op_a`, `op_b` in 16 each: operands, sampled on the accept edge.
- `result` out 32: product. Reset value 0.
- `result_valid` out 1: result-valid flag. Reset value 0.
- `result_ready` in 1: client accepts the result.
- `error` out 1: qualified by `result_valid`; 1 means a timeout occurred. Reset value 0.
- `bus_cs`, `bus_rd`, `bus_wr` out 1 each: peripheral chip-select, read strobe and write strobe. Reset value 0.
- `bus_addr` out 5: peripheral register address. Reset value 0.
- `bus_dout` out 16: write data to the peripheral. Reset value 0.
- `bus_din` in 32: read data from the peripheral. The peripheral registers it, so it is valid one cycle after the address is presented.

## Operation
- Register offsets: A = 0x04, B = 0x08, INIT = 0x0C, PP = 0x10, DONE = 0x14.
- FSM states: IDLE → WR_A → WR_B → WR_INIT1 → WR_INIT0 → RD_DONE_A ⇄ RD_DONE_D → RD_PP_A → RD_PP_D → RESP → IDLE.
- IDLE
  - Bus signals are all 0.
  - When `start` is high, latch `op_a`/`op_b`, clear the poll counter and go to WR_A.
- WR_A and WR_B
  - Drive `bus_cs=1`, `bus_wr=1`, `bus_addr` = 0x04 or 0x08, `bus_dout` = latched a or b.
  - Each state lasts one cycle.
- WR_INIT1 and WR_INIT0
  - Write 1, then 0, to offset 0x0C, one cycle each.
  - Result: the peripheral's init is high for exactly one cycle.
- RD_DONE_A
  - Drive `bus_cs=1`, `bus_rd=1`, `bus_addr`=0x14.
- RD_DONE_D
  - Keep the same bus drive and sample `bus_din[0]`.
  - If it is 1, go to RD_PP_A.
  - Otherwise increment the poll counter.
  - If the counter reaches `TIMEOUT`, go to RESP with `error=1` and `result=0`; else go back to RD_DONE_A.
- RD_PP_A and RD_PP_D
  - Drive a read of offset 0x10.
  - In RD_PP_D, capture `bus_din` into `result` and set `error=0`.
- RESP
  - Bus is idle; `result_valid=1`.
  - `result`/`error` are held stable until `result_ready` is high; on that edge, clear `result_valid` and go to IDLE.
- Outside the listed states, `bus_rd` and `bus_wr` are never high. `bus_rd` and `bus_wr` are never high together.
- The poll counter is `clog2(TIMEOUT+1)` bits wide and saturates; it never wraps.

## Timing
- Count the accept edge as edge 0. The bus phases are then:
  - cycles 1–4: the four writes;
  - cycles 5–6: first done-poll;
  - cycles 7–8: pp read.
- With done seen on the first poll, `result_valid` rises in cycle 9; this is the minimum latency.
- Each failed poll adds 2 cycles.
- `start_ready` is 0 from cycle 1 until the cycle after result acceptance.
  - Back-to-back operation: 1 idle cycle between results.
- `start` while busy is ignored; no queuing.
- `result_ready` held high before RESP: the result is accepted in its first RESP cycle, so `result_valid` is high for exactly 1 cycle.
- `reset` asserted in any state:
  - the bus is released in the same cycle;
  - `result_valid`/`error`/`result` go to 0;
  - any in-flight operation is discarded;
  - the peripheral's own reset governs its state.

## Structure
- Shared package `mult_bus_pkg` holds:
  - the five register offset constants (shared with the peripheral);
  - the FSM state encoding;
  - the `DATA_W`/`ADDR_W` defaults.
- One natural sub-module: `mult_poll_timer`, the saturating poll counter with clear, increment and expired outputs.
- Everything else lives in a single always_ff FSM plus output decode.

## Test plan
- Bench uses a behavioural peripheral model with a registered `d_out` and done after N cycles.
- a=3, b=5, done on first poll → bus writes the sequence (0x04,3), (0x08,5), (0x0C,1), (0x0C,0); `result`=15 and `error=0` with `result_valid` in cycle 9.
- a=0xFFFF, b=0xFFFF, done after 6 failed polls → `result`=0xFFFE0001, valid in cycle 21.
- `TIMEOUT`=4 and done never asserted → exactly 4 polls, then `result_valid=1`, `error=1`, `result=0`, and no PP read.
- `result_ready` held low for 10 cycles → `result`/`valid` stable throughout; `start` pulsed during that window is ignored.
- `reset` dropped during RD_DONE_A → bus signals 0 in the same cycle; after release, `start_ready=1`, and a new a=7, b=6 yields 42.
- Back-to-back: a second `start` held high, `result_ready` tied high → second accept occurs one cycle after the first result; no bus overlap is ever observed.

Source files
------------

// File: rtl/mult_bus_pkg.sv
// Shared definitions for the multiplier peripheral bus: register map, FSM encoding
// and default widths used by the bus initiator and the peripheral.
package mult_bus_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_ADDR_W  = 5;
    localparam int DEF_TIMEOUT = 1023;

    localparam logic [DEF_ADDR_W-1:0] REG_A    = 5'h04;
    localparam logic [DEF_ADDR_W-1:0] REG_B    = 5'h08;
    localparam logic [DEF_ADDR_W-1:0] REG_INIT = 5'h0C;
    localparam logic [DEF_ADDR_W-1:0] REG_PP   = 5'h10;
    localparam logic [DEF_ADDR_W-1:0] REG_DONE = 5'h14;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_A,
        ST_WR_B,
        ST_WR_INIT1,
        ST_WR_INIT0,
        ST_RD_DONE_A,
        ST_RD_DONE_D,
        ST_RD_PP_A,
        ST_RD_PP_D,
        ST_RESP
    } state_t;

    // Width that holds 0..timeout inclusive; never narrower than one bit.
    function automatic int poll_cnt_w(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mult_bus_master_if.sv
// Client handshake plus peripheral bus port of the multiplier bus initiator.
// The master modport is the initiator's view; slave is the client/peripheral side.
interface mult_bus_master_if
    import mult_bus_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) ();

    logic                  start;
    logic                  start_ready;
    logic [DATA_W-1:0]     op_a;
    logic [DATA_W-1:0]     op_b;
    logic [2*DATA_W-1:0]   result;
    logic                  result_valid;
    logic                  result_ready;
    logic                  error;

    logic                  bus_cs;
    logic                  bus_rd;
    logic                  bus_wr;
    logic [ADDR_W-1:0]     bus_addr;
    logic [DATA_W-1:0]     bus_dout;
    logic [2*DATA_W-1:0]   bus_din;

    modport master (
        input  start, op_a, op_b, result_ready, bus_din,
        output start_ready, result, result_valid, error,
        output bus_cs, bus_rd, bus_wr, bus_addr, bus_dout
    );

    modport slave (
        output start, op_a, op_b, result_ready, bus_din,
        input  start_ready, result, result_valid, error,
        input  bus_cs, bus_rd, bus_wr, bus_addr, bus_dout
    );

endinterface

// File: rtl/mult_poll_timer.sv
// Saturating done-poll counter; expired flags the increment that reaches TIMEOUT.
// TIMEOUT is expected to be at least 1.
module mult_poll_timer
    import mult_bus_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic incr,
    output logic expired
);

    localparam int               CNT_W = poll_cnt_w(TIMEOUT);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (incr && count != LIMIT) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = incr && (count >= LIMIT - CNT_W'(1));

endmodule

// File: rtl/mult_bus_master.sv
// Bus initiator for the multiplier peripheral: write A, write B, pulse init,
// poll done, read pp, then hand the product (or a timeout error) back to the client.
module mult_bus_master
    import mult_bus_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input logic               clk,
    input logic               reset,
    mult_bus_master_if.master bus
);

    state_t                state;
    state_t                state_nxt;
    logic [DATA_W-1:0]     a_q;
    logic [DATA_W-1:0]     b_q;
    logic [2*DATA_W-1:0]   result_q;
    logic                  error_q;

    logic                  poll_clear;
    logic                  poll_incr;
    logic                  poll_expired;

    logic                  cs;
    logic                  rd;
    logic                  wr;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     dout;

    mult_poll_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_poll_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (poll_clear),
        .incr    (poll_incr),
        .expired (poll_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && bus.start) begin
                a_q <= bus.op_a;
                b_q <= bus.op_b;
            end
            // The pp read and the timeout abort are the only writers of the response.
            if (state == ST_RD_PP_D) begin
                result_q <= bus.bus_din;
                error_q  <= 1'b0;
            end else if (poll_incr && poll_expired) begin
                result_q <= '0;
                error_q  <= 1'b1;
            end
        end
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        state_nxt  = state;
        cs         = 1'b0;
        rd         = 1'b0;
        wr         = 1'b0;
        addr       = '0;
        dout       = '0;
        poll_clear = 1'b0;
        poll_incr  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    poll_clear = 1'b1;
                    state_nxt  = ST_WR_A;
                end
            end
            ST_WR_A: begin
                {cs, wr}  = 2'b11;
                addr      = ADDR_W'(REG_A);
                dout      = a_q;
                state_nxt = ST_WR_B;
            end
            ST_WR_B: begin
                {cs, wr}  = 2'b11;
                addr      = ADDR_W'(REG_B);
                dout      = b_q;
                state_nxt = ST_WR_INIT1;
            end
            ST_WR_INIT1: begin
                {cs, wr}  = 2'b11;
                addr      = ADDR_W'(REG_INIT);
                dout      = DATA_W'(1);
                state_nxt = ST_WR_INIT0;
            end
            ST_WR_INIT0: begin
                {cs, wr}  = 2'b11;
                addr      = ADDR_W'(REG_INIT);
                state_nxt = ST_RD_DONE_A;
            end
            ST_RD_DONE_A: begin
                {cs, rd}  = 2'b11;
                addr      = ADDR_W'(REG_DONE);
                state_nxt = ST_RD_DONE_D;
            end
            ST_RD_DONE_D: begin
                {cs, rd} = 2'b11;
                addr     = ADDR_W'(REG_DONE);
                if (bus.bus_din[0]) begin
                    state_nxt = ST_RD_PP_A;
                end else begin
                    poll_incr = 1'b1;
                    state_nxt = poll_expired ? ST_RESP : ST_RD_DONE_A;
                end
            end
            ST_RD_PP_A: begin
                {cs, rd}  = 2'b11;
                addr      = ADDR_W'(REG_PP);
                state_nxt = ST_RD_PP_D;
            end
            ST_RD_PP_D: begin
                {cs, rd}  = 2'b11;
                addr      = ADDR_W'(REG_PP);
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (bus.result_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.bus_cs       = cs;
    assign bus.bus_rd       = rd;
    assign bus.bus_wr       = wr;
    assign bus.bus_addr     = addr;
    assign bus.bus_dout     = dout;
    assign bus.start_ready  = (state == ST_IDLE);
    assign bus.result_valid = (state == ST_RESP);
    assign bus.result       = result_q;
    assign bus.error        = error_q;

endmodule
